// File: rtl/cpu_io_ctrl.sv
// I/O controller for the single-cycle CPU: executes IN/OUT/HALT, debounces Enter
// and stalls the PC until an IN handshake or HALT completes.
//
// state        | meaning
// IDLE         | no operation pending; OUT completes here with zero latency
// WAIT_PRESS   | IN pending, waiting for a fresh debounced Enter press
// WAIT_RELEASE | switches captured, waiting for Enter release
// DONE         | one-cycle write-back strobe, stall released
// HALTED       | CPU stopped until reset
module cpu_io_ctrl #(
  parameter int DATA_W       = 32,
  parameter int SW_W         = 10,
  parameter int N_OUT        = 2,
  parameter int SEL_W        = 1,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    in_req,
  input  logic                    out_req,
  input  logic                    halt_req,
  input  logic [SEL_W-1:0]        out_sel,
  input  logic [DATA_W-1:0]       out_data,
  input  logic                    enter,
  input  logic [SW_W-1:0]         sw,
  output logic                    stall,
  output logic [DATA_W-1:0]       in_data,
  output logic                    in_valid,
  output logic [N_OUT*DATA_W-1:0] out_value,
  output logic                    halted,
  output logic [2:0]              state
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_PRESS   = 3'd1,
    WAIT_RELEASE = 3'd2,
    DONE         = 3'd3,
    HALTED       = 3'd4
  } state_t;

  state_t           cur, nxt;
  logic             sync1, sync2;
  logic             db_level, db_prev;
  logic [CNT_W-1:0] db_cnt;
  logic             db_rise;
  logic             out_wr;

  // Level flips on the DEBOUNCE_CYC-th consecutive disagreeing sample.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1   <= enter;
      sync2   <= sync1;
      db_prev <= db_level;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  // Registered edge, so a level already high on entry to WAIT_PRESS is not a press.
  assign db_rise = db_level & ~db_prev;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) cur <= IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt      = cur;
    stall    = 1'b0;
    in_valid = 1'b0;
    halted   = 1'b0;
    unique case (cur)
      IDLE: begin
        if (halt_req) begin
          stall = 1'b1;
          nxt   = HALTED;
        end else if (in_req) begin
          stall = 1'b1;
          nxt   = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        stall = 1'b1;
        if (db_rise) nxt = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        stall = 1'b1;
        if (!db_level) nxt = DONE;
      end
      DONE: begin
        in_valid = 1'b1;
        nxt      = IDLE;
      end
      HALTED: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)                          in_data <= '0;
    else if (cur == WAIT_PRESS && db_rise) in_data <= DATA_W'(sw);
  end

  assign out_wr = (cur == IDLE) && out_req && !halt_req && !in_req;

  // An out-of-range out_sel matches no channel index, so nothing is written.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      out_value <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (out_wr && out_sel == SEL_W'(k))
          out_value[k*DATA_W +: DATA_W] <= out_data;
      end
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_cpu_io_ctrl.sv
// Self-checking bench for cpu_io_ctrl: vector table, directed handshake sequences
// and randomized traffic against a behavioural model.
module tb_cpu_io_ctrl;

  localparam int D = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_WP = 3'd1, S_WR = 3'd2, S_DONE = 3'd3, S_HALT = 3'd4;

  logic        CLK = 1'b0;
  logic        reset, in_req, out_req, halt_req, enter;
  logic [0:0]  out_sel;
  logic [31:0] out_data;
  logic [9:0]  sw;
  logic        stall, in_valid, halted;
  logic [31:0] in_data;
  logic [63:0] out_value;
  logic [2:0]  state;

  logic        o3_req;
  logic [1:0]  o3_sel;
  logic [31:0] o3_data;
  logic        s3_stall, s3_valid, s3_halted;
  logic [31:0] s3_in_data;
  logic [95:0] s3_ov;
  logic [2:0]  s3_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  cpu_io_ctrl dut (
    .CLK(CLK), .reset(reset), .in_req(in_req), .out_req(out_req), .halt_req(halt_req),
    .out_sel(out_sel), .out_data(out_data), .enter(enter), .sw(sw), .stall(stall),
    .in_data(in_data), .in_valid(in_valid), .out_value(out_value), .halted(halted),
    .state(state)
  );

  cpu_io_ctrl #(.N_OUT(3), .SEL_W(2)) dut3 (
    .CLK(CLK), .reset(reset), .in_req(1'b0), .out_req(o3_req), .halt_req(1'b0),
    .out_sel(o3_sel), .out_data(o3_data), .enter(1'b0), .sw(10'd0), .stall(s3_stall),
    .in_data(s3_in_data), .in_valid(s3_valid), .out_value(s3_ov), .halted(s3_halted),
    .state(s3_state)
  );

  // Behavioural model: debounced level flips once the last D synchronised
  // samples (enter seen two edges earlier) all disagree with it.
  typedef enum int {M_IDLE, M_WP, M_WR, M_DONE, M_HALT} phase_t;
  phase_t      m_phase;
  bit          m_hist[$];
  bit          m_lvl, m_prev;
  logic [31:0] m_in;
  logic [31:0] m_ch[2];

  task automatic model_reset();
    m_hist.delete();
    m_lvl = 0; m_prev = 0; m_phase = M_IDLE; m_in = 0;
    m_ch[0] = 0; m_ch[1] = 0;
  endtask

  task automatic model_edge();
    bit flip;
    if (!reset) begin
      model_reset();
    end else begin
      case (m_phase)
        M_IDLE: begin
          if (halt_req)     m_phase = M_HALT;
          else if (in_req)  m_phase = M_WP;
          else if (out_req) m_ch[out_sel] = out_data;
        end
        M_WP:   if (m_lvl && !m_prev) begin m_in = 32'(sw); m_phase = M_WR; end
        M_WR:   if (!m_lvl) m_phase = M_DONE;
        M_DONE: m_phase = M_IDLE;
        default: ;
      endcase
      flip = 1;
      for (int k = 0; k < D; k++) begin
        bit s;
        s = (k + 1 < m_hist.size()) ? m_hist[k+1] : 1'b0;
        if (s == m_lvl) flip = 0;
      end
      m_prev = m_lvl;
      if (flip) m_lvl = ~m_lvl;
      m_hist.push_front(enter);
      if (m_hist.size() > D + 2) void'(m_hist.pop_back());
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic e_stall;
    e_stall = (m_phase == M_IDLE) ? (halt_req | in_req) : (m_phase != M_DONE);
    chk("m_stall",    stall,     e_stall);
    chk("m_in_valid", in_valid,  m_phase == M_DONE);
    chk("m_halted",   halted,    m_phase == M_HALT);
    chk("m_in_data",  in_data,   m_in);
    chk("m_out",      out_value, {m_ch[1], m_ch[0]});
  endtask

  task automatic settle(); #1; check_all(); endtask
  task automatic adv(); @(posedge CLK); model_edge(); @(negedge CLK); endtask
  task automatic tick(); settle(); adv(); endtask

  task automatic idle_in();
    in_req = 0; out_req = 0; halt_req = 0;
  endtask

  task automatic do_reset();
    reset = 0; model_reset(); tick(); reset = 1;
  endtask

  task automatic wait_valid(input string nm);
    bit seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      settle();
      if (in_valid) begin
        seen = 1;
        chk({nm, "_done_stall"}, stall, 0);
      end
      adv();
    end
    if (!seen) chk({nm, "_timeout"}, 0, 1);
    in_req = 0;
    settle();
    chk({nm, "_valid_single"}, in_valid, 0);
    chk({nm, "_stall_after"}, stall, 0);
    adv();
  endtask

  task automatic run_in(input logic [9:0] v);
    in_req = 1; sw = v; enter = 0;
    repeat (3) tick();
    enter = 1; repeat (10) tick();
    enter = 0;
    wait_valid("run_in");
  endtask

  typedef struct {
    logic in_r, out_r, halt_r;
    logic [0:0] sel;
    logic [31:0] data;
    logic exp_stall;
    logic [63:0] exp_ov;
    logic exp_halted;
  } vec_t;
  vec_t vt[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int halt_cnt;
    int burst;
    vt[0] = '{0, 1, 0, 1'b1, 32'hDEADBEEF, 0, 64'hDEADBEEF_00000000, 0};
    vt[1] = '{0, 1, 0, 1'b0, 32'h00000012, 0, 64'hDEADBEEF_00000012, 0};
    vt[2] = '{0, 0, 0, 1'b1, 32'h00000005, 0, 64'hDEADBEEF_00000012, 0};
    vt[3] = '{0, 1, 0, 1'b0, 32'h0000CAFE, 0, 64'hDEADBEEF_0000CAFE, 0};
    vt[4] = '{1, 1, 1, 1'b1, 32'h00000777, 1, 64'hDEADBEEF_0000CAFE, 1};

    reset = 0; idle_in(); enter = 0; sw = 0; out_sel = 0; out_data = 0;
    o3_req = 0; o3_sel = 0; o3_data = 0;
    model_reset();
    @(negedge CLK);
    #1;
    chk("rst_state", state, S_IDLE);
    chk("rst_stall", stall, 0);
    chk("rst_in_data", in_data, 0);
    chk("rst_out", out_value, 0);
    chk("rst_halted", halted, 0);
    adv(); adv();
    reset = 1;
    tick();

    // IN handshake with explicit latency checks
    in_req = 1; sw = 10'h155;
    settle();
    chk("in_stall_same_cycle", stall, 1);
    adv();
    enter = 1;
    for (int t = 0; t < 10; t++) begin
      settle();
      chk("in_stall_wait", stall, 1);
      if (t == 6) chk("in_data_before_cap", in_data, 0);
      if (t == 7) chk("in_data_cap", in_data, 32'h155);
      adv();
    end
    enter = 0;
    wait_valid("in_hs");

    // OUT / priority table
    for (int i = 0; i < 5; i++) begin
      in_req = vt[i].in_r; out_req = vt[i].out_r; halt_req = vt[i].halt_r;
      out_sel = vt[i].sel; out_data = vt[i].data;
      settle();
      chk("vec_stall", stall, vt[i].exp_stall);
      adv();
      chk("vec_out", out_value, vt[i].exp_ov);
      chk("vec_halted", halted, vt[i].exp_halted);
    end

    // Halted: sticky despite enter and requests
    for (int t = 0; t < 100; t++) begin
      enter = (t % 7) < 3;
      in_req = $urandom_range(0, 1); out_req = $urandom_range(0, 1);
      halt_req = $urandom_range(0, 1); out_data = $urandom;
      settle();
      chk("halt_stall", stall, 1);
      chk("halt_halted", halted, 1);
      adv();
    end
    idle_in(); enter = 0;
    reset = 0; model_reset();
    settle();
    chk("halt_exit_state", state, S_IDLE);
    adv();
    reset = 1;

    // Async reset in the middle of WAIT_PRESS
    run_in(10'h3A5);
    out_req = 1; out_sel = 1; out_data = 32'h0000ABCD; tick(); idle_in();
    in_req = 1; sw = 10'h3FF; tick(); in_req = 0;
    for (int t = 0; t < 6; t++) begin enter = ~enter; tick(); end
    reset = 0; model_reset();
    settle();
    chk("mid_rst_state", state, S_IDLE);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_in_data", in_data, 0);
    chk("mid_rst_out", out_value, 0);
    chk("mid_rst_halted", halted, 0);
    adv();
    reset = 1; enter = 0;
    repeat (8) tick();

    // Glitch rejection
    run_in(10'h155);
    in_req = 1; sw = 10'h2AA; tick(); in_req = 0;
    for (int t = 0; t < 18; t++) begin
      enter = (t < 3) || (t >= 5 && t < 8);
      settle();
      chk("glitch_state", state, S_WP);
      adv();
    end
    chk("glitch_in_data", in_data, 32'h155);
    do_reset();

    // Button already held before in_req
    enter = 1; repeat (20) tick();
    in_req = 1; sw = 10'h0F0; tick(); in_req = 0;
    repeat (10) tick();
    chk("held_state", state, S_WP);
    chk("held_no_cap", in_data, 0);
    enter = 0; repeat (10) tick();
    sw = 10'h321; enter = 1; repeat (10) tick();
    enter = 0;
    in_req = 1;
    wait_valid("held");
    chk("held_in_data", in_data, 32'h321);

    // Three-channel instance: out-of-range select writes nothing
    o3_req = 1; o3_sel = 2'd1; o3_data = 32'hAAAA5555; adv();
    o3_sel = 2'd3; o3_data = 32'hFFFFFFFF; adv();
    o3_req = 0;
    #1;
    chk("n3_ch0", s3_ov[31:0], 0);
    chk("n3_ch1", s3_ov[63:32], 32'hAAAA5555);
    chk("n3_ch2", s3_ov[95:64], 0);
    chk("n3_ctrl", {s3_stall, s3_valid, s3_halted, s3_state, s3_in_data}, 0);

    // Randomized traffic against the model
    halt_cnt = 0; burst = 0;
    for (int c = 0; c < 4000; c++) begin
      if (burst == 0) begin enter = $urandom_range(0, 1); burst = $urandom_range(1, 12); end
      burst--;
      in_req   = ($urandom_range(0, 19) == 0);
      out_req  = ($urandom_range(0, 3) == 0);
      halt_req = ($urandom_range(0, 399) == 0);
      out_sel  = 1'($urandom_range(0, 1));
      out_data = $urandom;
      sw       = 10'($urandom);
      if (m_phase == M_HALT) halt_cnt++;
      if (halt_cnt > 30 || $urandom_range(0, 699) == 0) begin
        halt_cnt = 0;
        do_reset();
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_io_ctrl.md
Name: cpu_io_ctrl

Overview:
- Parametrised successor to the processor's I/O path.
- Executes IN, OUT and HALT instructions for the single-cycle CPU.
- Supports N_OUT independent output channels, switch input of configurable width, and a synchronised, debounced Enter handshake.
- Drives a stall line that holds the PC/clock until the operation completes; sits between the Control decoder, register file write-back mux and board I/O.

Parameters:
DATA_W, 32, width of CPU data path (in_data, out_data, each output channel)
SW_W, 10, number of board switches; must be <= DATA_W
N_OUT, 2, number of output channels (>= 1)
SEL_W, 1, width of out_sel; must satisfy 2**SEL_W >= N_OUT
DEBOUNCE_CYC, 4, consecutive stable synchronised samples required to accept an Enter level change (>= 1)

Ports:
CLK  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
in_req  in  1  decoder: current instruction is IN
out_req  in  1  decoder: current instruction is OUT
halt_req  in  1  decoder: current instruction is HALT
out_sel  in  SEL_W  target output channel for OUT
out_data  in  DATA_W  value for OUT (Read_Data1)
enter  in  1  raw Enter button, active-high, asynchronous to CLK
sw  in  SW_W  board switches, sampled at accepted press
stall  out  1  hold PC and register/memory writes while 1
in_data  out  DATA_W  value written back by IN
in_valid  out  1  one-cycle strobe: in_data is valid this cycle
out_value  out  N_OUT*DATA_W  flattened channel registers; channel k at bits [k*DATA_W +: DATA_W]
halted  out  1  1 in HALTED state
state  out  3  FSM state encoding, for debug

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, stall=0, in_data=0, in_valid=0, all out_value=0, halted=0, synchroniser flops=0, debounced level=0, debounce counter=0.
- Enter conditioning: 2-flop synchroniser, then debouncer. Debounced level changes only after the synchronised value differs from it for DEBOUNCE_CYC consecutive cycles; any mismatch-free cycle clears the counter. Runs in every state.
- FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE, HALTED.
- Request priority in IDLE: halt_req > in_req > out_req. Requests in any other state are ignored.
- IDLE + halt_req: stall=1 combinationally in the same cycle; next state HALTED.
- IDLE + in_req: stall=1 combinationally in the same cycle; next state WAIT_PRESS.
- IDLE + out_req: stall=0; at the clock edge, channel out_sel <= out_data. If out_sel >= N_OUT, no channel changes. Zero added latency.
- WAIT_PRESS: stall=1. On debounced rising edge (level 0->1), in_data <= zero-extended sw; next state WAIT_RELEASE. If the debounced level is already 1 on entry, wait for release then a fresh press. No rising edge is taken on entry.
- WAIT_RELEASE: stall=1. On debounced level 0, next state DONE.
- DONE: one cycle; stall=0, in_valid=1. CPU writes in_data and advances PC at this edge. Next state is IDLE unconditionally, so the same IN cannot retrigger.
- HALTED: stall=1, halted=1. Exits only via reset; enter is ignored.
- in_data holds its value until the next accepted press. out_value channels hold until rewritten or reset.
- Reset asserted mid-operation (any state) aborts immediately to IDLE with reset values; a pending IN is lost.
- Minimum IN latency: press held >= 2+DEBOUNCE_CYC cycles and released similarly. stall is high from the in_req cycle through WAIT_RELEASE.

Test Plan:
- Reset check: hold reset=0 mid-WAIT_PRESS with sw=10'h3FF and enter toggling -> state=IDLE, stall=0, in_data=0, out_value=0, halted=0 immediately, before any CLK edge.
- OUT to both channels (N_OUT=2): out_req, out_sel=1, out_data=32'hDEADBEEF; next cycle out_sel=0, out_data=32'h12 -> out_value=64'hDEADBEEF_00000012; stall never 1. A further OUT with out_sel=1 when N_OUT=3, SEL_W=2, out_sel=3 -> no channel changes.
- IN handshake (DEBOUNCE_CYC=4): in_req held, sw=10'h155, enter high 10 cycles then low -> stall rises in the same cycle as in_req; in_data=32'h155 at the 7th cycle after press; in_valid single pulse with stall=0 in DONE; stall low afterwards.
- Glitch rejection: in WAIT_PRESS, enter high for 3 cycles, low 2, high 3 (DEBOUNCE_CYC=4) -> debounced level never rises, state stays WAIT_PRESS, in_data unchanged.
- Held button: enter already held high 20 cycles before in_req -> no capture until release then a new press; captured value is sw at the new press.
- Priority/halt: halt_req=in_req=out_req=1 in IDLE -> HALTED, out_value unchanged, stall=1, halted=1 for 100 cycles despite enter pulses; reset=0 returns to IDLE.
